// File: rtl/alu_cmd_sequencer.sv
// Command-side front end for the 32-bit ALU: takes ops over valid/ready, drives the ALU pins,
// returns the captured result over valid/ready and keeps sticky Z/N plus a completed-command count.
//
// state | meaning
// IDLE  | ready for a command; ALU pins hold their last values
// EXEC  | latched op on the ALU pins for one full cycle; result captured at the end
// RESP  | response presented until the consumer takes it
module alu_cmd_sequencer #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_a,
    input  logic [WIDTH-1:0] cmd_b,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic             alu_add,
    output logic             alu_neg,
    output logic             alu_sub,
    input  logic [WIDTH-1:0] alu_out,
    input  logic             alu_z,
    input  logic             alu_n,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp_z,
    output logic             rsp_n,
    output logic             rsp_err,
    output logic             flag_z,
    output logic             flag_n,
    output logic [CNT_W-1:0] done_cnt
);

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_NEG  = 3'b010;
    localparam logic [2:0] OP_PASS = 3'b011;
    localparam logic [2:0] OP_CMP  = 3'b100;

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t state_q, state_d;

    logic             cmd_fire, rsp_fire;
    logic             cmp_q, ill_q;
    logic [WIDTH-1:0] dec_a, dec_b;
    logic             dec_add, dec_neg, dec_sub, dec_cmp, dec_ill;

    assign cmd_fire = cmd_valid && cmd_ready;
    assign rsp_fire = rsp_valid && rsp_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (cmd_valid) state_d = EXEC;
            EXEC:    state_d = RESP;
            RESP:    if (rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cmd_ready = (state_q == IDLE);
        rsp_valid = (state_q == RESP);
    end

    // The ALU encodes subtract as add=1/sub=1 and negate as add=1/neg=1; PASS is A-0.
    always_comb begin
        dec_a   = cmd_a;
        dec_b   = '0;
        dec_add = 1'b0;
        dec_neg = 1'b0;
        dec_sub = 1'b0;
        dec_cmp = 1'b0;
        dec_ill = 1'b0;
        case (cmd_op)
            OP_ADD: dec_b = cmd_b;
            OP_SUB, OP_CMP: begin
                dec_b   = cmd_b;
                dec_add = 1'b1;
                dec_sub = 1'b1;
                dec_cmp = (cmd_op == OP_CMP);
            end
            OP_NEG: begin
                dec_add = 1'b1;
                dec_neg = 1'b1;
            end
            OP_PASS: begin
                dec_add = 1'b1;
                dec_sub = 1'b1;
            end
            default: begin
                dec_a   = '0;
                dec_ill = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            alu_a    <= '0;
            alu_b    <= '0;
            alu_add  <= 1'b0;
            alu_neg  <= 1'b0;
            alu_sub  <= 1'b0;
            cmp_q    <= 1'b0;
            ill_q    <= 1'b0;
            rsp_data <= '0;
            rsp_z    <= 1'b0;
            rsp_n    <= 1'b0;
            rsp_err  <= 1'b0;
            flag_z   <= 1'b0;
            flag_n   <= 1'b0;
            done_cnt <= '0;
        end else begin
            if (cmd_fire) begin
                alu_a   <= dec_a;
                alu_b   <= dec_b;
                alu_add <= dec_add;
                alu_neg <= dec_neg;
                alu_sub <= dec_sub;
                cmp_q   <= dec_cmp;
                ill_q   <= dec_ill;
            end
            if (state_q == EXEC) begin
                rsp_data <= (cmp_q || ill_q) ? '0 : alu_out;
                rsp_z    <= alu_z && !ill_q;
                rsp_n    <= alu_n && !ill_q;
                rsp_err  <= ill_q;
            end
            if (rsp_fire) begin
                if (done_cnt != '1) begin
                    done_cnt <= done_cnt + CNT_W'(1);
                end
                if (!rsp_err) begin
                    flag_z <= rsp_z;
                    flag_n <= rsp_n;
                end
            end
        end
    end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed bench for alu_cmd_sequencer with a behavioural ALU on the pins; a second
// instance with a 2-bit counter runs the same stream to exercise saturation.
module tb_alu_cmd_sequencer;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         cmd_valid;
    logic [2:0]   cmd_op;
    logic [W-1:0] cmd_a, cmd_b;
    logic         rsp_ready;

    logic         cmd_ready, rsp_valid, rsp_z, rsp_n, rsp_err, flag_z, flag_n;
    logic [W-1:0] alu_a, alu_b, alu_out, rsp_data;
    logic         alu_add, alu_neg, alu_sub, alu_z, alu_n;
    logic [15:0]  done_cnt;

    logic         s_cmd_ready, s_rsp_valid, s_rsp_z, s_rsp_n, s_rsp_err, s_flag_z, s_flag_n;
    logic [W-1:0] s_alu_a, s_alu_b, s_alu_out, s_rsp_data;
    logic         s_alu_add, s_alu_neg, s_alu_sub, s_alu_z, s_alu_n;
    logic [1:0]   s_done_cnt;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    // External ALU: 000 add, 101 subtract, 110 negate.
    function automatic logic [W+1:0] alu_f(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic add, input logic neg, input logic sub);
        logic [W-1:0] r;
        case ({add, neg, sub})
            3'b101:  r = a - b;
            3'b110:  r = W'(0) - a;
            default: r = a + b;
        endcase
        return {(r == '0), r[W-1], r};
    endfunction

    assign {alu_z, alu_n, alu_out}       = alu_f(alu_a, alu_b, alu_add, alu_neg, alu_sub);
    assign {s_alu_z, s_alu_n, s_alu_out} = alu_f(s_alu_a, s_alu_b, s_alu_add, s_alu_neg, s_alu_sub);

    alu_cmd_sequencer #(.WIDTH(W), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b),
        .alu_a(alu_a), .alu_b(alu_b), .alu_add(alu_add), .alu_neg(alu_neg), .alu_sub(alu_sub),
        .alu_out(alu_out), .alu_z(alu_z), .alu_n(alu_n),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_z(rsp_z),
        .rsp_n(rsp_n), .rsp_err(rsp_err), .flag_z(flag_z), .flag_n(flag_n), .done_cnt(done_cnt)
    );

    alu_cmd_sequencer #(.WIDTH(W), .CNT_W(2)) u_sat (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(s_cmd_ready), .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b),
        .alu_a(s_alu_a), .alu_b(s_alu_b), .alu_add(s_alu_add), .alu_neg(s_alu_neg), .alu_sub(s_alu_sub),
        .alu_out(s_alu_out), .alu_z(s_alu_z), .alu_n(s_alu_n),
        .rsp_valid(s_rsp_valid), .rsp_ready(rsp_ready), .rsp_data(s_rsp_data), .rsp_z(s_rsp_z),
        .rsp_n(s_rsp_n), .rsp_err(s_rsp_err), .flag_z(s_flag_z), .flag_n(s_flag_n), .done_cnt(s_done_cnt)
    );

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Present a command for one edge, then scramble the command bus to show it is ignored.
    task automatic issue(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_a     = a;
        cmd_b     = b;
        step();
        cmd_valid = 1'b0;
        cmd_op    = 3'b000;
        cmd_a     = 32'hDEAD_BEEF;
        cmd_b     = 32'h1234_5678;
    endtask

    task automatic pins(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [2:0] ctl);
        chk({tag, " cmd_ready"}, W'(cmd_ready), 0);
        chk({tag, " alu_a"}, alu_a, a);
        chk({tag, " alu_b"}, alu_b, b);
        chk({tag, " alu ctl"}, W'({alu_add, alu_neg, alu_sub}), W'(ctl));
    endtask

    task automatic resp(input string tag, input logic [W-1:0] data, input logic z,
                        input logic n, input logic err);
        chk({tag, " rsp_valid"}, W'(rsp_valid), 1);
        chk({tag, " rsp_data"}, rsp_data, data);
        chk({tag, " rsp z/n/err"}, W'({rsp_z, rsp_n, rsp_err}), W'({z, n, err}));
    endtask

    task automatic take();
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
    endtask

    task automatic after(input string tag, input logic z, input logic n, input int cnt);
        chk({tag, " idle cmd_ready"}, W'(cmd_ready), 1);
        chk({tag, " idle rsp_valid"}, W'(rsp_valid), 0);
        chk({tag, " flags"}, W'({flag_z, flag_n}), W'({z, n}));
        chk({tag, " done_cnt"}, W'(done_cnt), W'(cnt));
    endtask

    initial begin
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_op    = 3'b000;
        cmd_a     = '0;
        cmd_b     = '0;
        rsp_ready = 1'b0;
        step(2);
        rst_n = 1'b1;
        step();

        chk("reset cmd_ready", W'(cmd_ready), 1);
        chk("reset rsp_valid", W'(rsp_valid), 0);
        chk("reset rsp_data", rsp_data, 0);
        chk("reset rsp z/n/err", W'({rsp_z, rsp_n, rsp_err}), 0);
        chk("reset alu pins", alu_a | alu_b | W'({alu_add, alu_neg, alu_sub}), 0);
        chk("reset flags", W'({flag_z, flag_n}), 0);
        chk("reset done_cnt", W'(done_cnt), 0);

        issue(3'b000, 32'd4, 32'd3);
        pins("ADD", 32'd4, 32'd3, 3'b000);
        chk("ADD exec rsp_valid", W'(rsp_valid), 0);
        step();
        resp("ADD", 32'd7, 1'b0, 1'b0, 1'b0);
        take();
        after("ADD", 1'b0, 1'b0, 1);
        chk("ADD pins hold in idle", alu_a, 32'd4);

        issue(3'b001, 32'd5, 32'd5);
        pins("SUB", 32'd5, 32'd5, 3'b101);
        step();
        resp("SUB", 32'd0, 1'b1, 1'b0, 1'b0);
        take();
        after("SUB", 1'b1, 1'b0, 2);

        issue(3'b100, 32'd2, 32'd3);
        pins("CMP", 32'd2, 32'd3, 3'b101);
        step();
        resp("CMP", 32'd0, 1'b0, 1'b1, 1'b0);
        take();
        after("CMP", 1'b0, 1'b1, 3);

        issue(3'b010, 32'd5, 32'd9);
        pins("NEG", 32'd5, 32'd0, 3'b110);
        step();
        resp("NEG", 32'hFFFF_FFFB, 1'b0, 1'b1, 1'b0);
        take();
        after("NEG", 1'b0, 1'b1, 4);

        issue(3'b110, 32'd8, 32'd9);
        pins("ILL", 32'd0, 32'd0, 3'b000);
        step();
        resp("ILL", 32'd0, 1'b0, 1'b0, 1'b1);
        take();
        after("ILL", 1'b0, 1'b1, 5);
        chk("SAT done_cnt after 5", W'(s_done_cnt), 3);

        issue(3'b011, 32'd5, 32'd7);
        pins("PASS", 32'd5, 32'd0, 3'b101);
        step();
        cmd_valid = 1'b1;
        cmd_op    = 3'b000;
        for (int i = 0; i < 5; i++) begin
            resp("PASS hold", 32'd5, 1'b0, 1'b0, 1'b0);
            chk("PASS hold cmd_ready", W'(cmd_ready), 0);
            step();
        end
        cmd_valid = 1'b0;
        take();
        after("PASS", 1'b0, 1'b0, 6);
        chk("SAT done_cnt after 6", W'(s_done_cnt), 3);

        issue(3'b010, 32'h8000_0000, 32'd0);
        step();
        resp("NEG wrap", 32'h8000_0000, 1'b0, 1'b1, 1'b0);
        take();
        after("NEG wrap", 1'b0, 1'b1, 7);

        issue(3'b000, 32'd1, 32'd1);
        step();
        chk("pre-reset rsp_valid", W'(rsp_valid), 1);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("RST rsp_valid", W'(rsp_valid), 0);
        chk("RST cmd_ready", W'(cmd_ready), 1);
        chk("RST done_cnt", W'(done_cnt), 0);
        chk("RST flags", W'({flag_z, flag_n}), 0);
        chk("RST rsp_data", rsp_data, 0);
        chk("RST alu_a", alu_a, 0);
        chk("RST sat done_cnt", W'(s_done_cnt), 0);

        issue(3'b001, 32'd3, 32'd10);
        step();
        resp("post-reset SUB", 32'hFFFF_FFF9, 1'b0, 1'b1, 1'b0);
        take();
        after("post-reset SUB", 1'b0, 1'b1, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
